// File: rtl/seven_segment_scanner_if.sv
// Display bus between the hex-word source and the scanner.
// The source drives number/dots; the scanner drives segments and digit enables.
interface seven_segment_scanner_if #(
    parameter int n_digits = 8
);
    logic [4*n_digits-1:0] number;
    logic [n_digits-1:0]   dots;
    logic [7:0]            abcdefgh;
    logic [n_digits-1:0]   digit;

    modport master (
        output number,
        output dots,
        input  abcdefgh,
        input  digit
    );

    modport slave (
        input  number,
        input  dots,
        output abcdefgh,
        output digit
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Round-robin common-anode 7-segment scanner with per-slot dead time.
// Optional SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seven_segment_scanner #(
    parameter int n_digits     = 8,
    parameter int strobe_width = 10,
    parameter int blank_cycles = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    seven_segment_scanner_if.slave  disp
);
    localparam int IW = (n_digits > 1) ? $clog2(n_digits) : 1;
    localparam logic [strobe_width-1:0] SLOT_MAX = '1;
    localparam logic [strobe_width-1:0] BLANK =
        strobe_width'(blank_cycles);
    localparam logic [IW-1:0] IDX_MAX = IW'(n_digits - 1);
    localparam logic [n_digits-1:0] ONE = n_digits'(1);

    logic [strobe_width-1:0] slot_q, slot_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*n_digits-1:0]   num_q, num_d;
    logic [n_digits-1:0]     dots_q, dots_d;
    logic [n_digits-1:0]     digit_q, digit_d;
    logic [7:0]              seg_q, seg_d;

    logic       in_blank;
    logic       snap;
    logic [3:0] nib;
    logic [6:0] seg_show;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    // Zero dead time must not produce a constant compare against zero.
    generate
        if (blank_cycles == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (slot_q < BLANK);
        end
    endgenerate

`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
    logic [n_digits-1:0] lz_mask;
    logic                run;

    // Walk down from the top nibble while the run of zeros holds.
    always_comb begin
        lz_mask = '0;
        run     = 1'b1;
        for (int k = n_digits - 1; k >= 1; k--) begin
            run        = run & (num_q[4*k +: 4] == 4'h0);
            lz_mask[k] = run;
        end
    end
`endif

    always_comb begin
        slot_d = slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_q == SLOT_MAX) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        snap   = (idx_q == '0) && (slot_q == '0);
        num_d  = snap ? disp.number : num_q;
        dots_d = snap ? disp.dots : dots_q;

        nib      = num_q[{idx_q, 2'b00} +: 4];
        seg_show = seg7(nib);
`ifdef SEVEN_SEGMENT_SCANNER_LEADING_ZERO_BLANK_EN
        if (lz_mask[idx_q]) begin
            seg_show = 7'h7F;
        end
`endif

        if (in_blank) begin
            digit_d = '0;
            seg_d   = 8'hFF;
        end else begin
            digit_d = ONE << idx_q;
            seg_d   = {~dots_q[idx_q], seg_show};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q  <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            dots_q  <= '0;
            digit_q <= '0;
            seg_q   <= 8'hFF;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            dots_q  <= dots_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
        end
    end

    assign disp.digit    = digit_q;
    assign disp.abcdefgh = seg_q;
endmodule
